cdr_lock_ctrl: RTL and testbench

Link-training sequencer for the CDR datapath. Holds the CDR in reset, releases it, waits for lock within a timeout, qualifies lock stability and data-transition activity, declares the link up, and retrains on loss of lock or loss of data activity. Sits between the link-management logic (enable, status) and the CDR instance (reset, lock, serial data).

---
 rtl/cdr_lock_ctrl.sv | 196 +++++++++++++++++++
 tb/tb_cdr_lock_ctrl.sv | 333 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cdr_lock_ctrl.sv
// Link-training sequencer for a CDR: resets the CDR, waits for lock, qualifies
// lock stability and data activity, then holds link-up and retrains on loss.
module cdr_lock_ctrl #(
  parameter int RST_CYCLES    = 8,
  parameter int LOCK_TIMEOUT  = 1024,
  parameter int STABLE_CYCLES = 64,
  parameter int NO_EDGE_LIMIT = 32,
  parameter int MAX_RETRY     = 3,
  parameter int CNT_W         = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       data_in,
  input  logic       cdr_lock,
  output logic       cdr_rst_n,
  output logic       link_up,
  output logic       fail,
  output logic [2:0] state,
  output logic [3:0] retry_cnt,
  output logic [7:0] loss_cnt
);

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_RESET     = 3'd1,
    ST_WAIT_LOCK = 3'd2,
    ST_VERIFY    = 3'd3,
    ST_LOCKED    = 3'd4,
    ST_FAIL      = 3'd5
  } state_t;

  localparam logic [CNT_W-1:0] RST_LAST    = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0] LOCK_LAST   = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] STABLE_LAST = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] NOEDGE_LAST = CNT_W'(NO_EDGE_LIMIT - 1);
  localparam logic [3:0]       RETRY_MAX   = 4'(MAX_RETRY);

  // Synchronisers and edge-detect history
  logic r_lock_m;
  logic r_lock_s;
  logic r_d1;
  logic r_d2;
  logic r_d3;

  state_t           r_state;
  logic [CNT_W-1:0] r_timer;
  logic [CNT_W-1:0] r_noedge;
  logic [3:0]       r_retry;
  logic [7:0]       r_loss;
  logic             r_cdr_rst_n;
  logic             r_link_up;
  logic             r_fail;

  logic             w_data_edge;
  logic             w_act_lost;
  logic             w_lock_lost;
  logic             w_attempt_fail;
  state_t           w_state_nxt;
  logic [CNT_W-1:0] w_timer_nxt;
  logic [CNT_W-1:0] w_noedge_nxt;
  logic [3:0]       w_retry_nxt;
  logic [7:0]       w_loss_nxt;

  assign w_data_edge = r_d2 ^ r_d3;
  assign w_act_lost  = (r_noedge == NOEDGE_LAST) && !w_data_edge;
  assign w_lock_lost = !r_lock_s || w_act_lost;

  // Priority: enable low, then loss/failure, then timer completion.
  always_comb begin
    w_state_nxt    = r_state;
    w_timer_nxt    = r_timer;
    w_retry_nxt    = r_retry;
    w_loss_nxt     = r_loss;
    w_attempt_fail = 1'b0;
    if (w_data_edge) begin
      w_noedge_nxt = '0;
    end else if (r_noedge == '1) begin
      w_noedge_nxt = r_noedge;
    end else begin
      w_noedge_nxt = r_noedge + 1'b1;
    end

    if (!enable) begin
      w_state_nxt  = ST_IDLE;
      w_timer_nxt  = '0;
      w_retry_nxt  = '0;
      w_noedge_nxt = '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          w_state_nxt  = ST_RESET;
          w_timer_nxt  = '0;
          w_retry_nxt  = '0;
          w_noedge_nxt = '0;
        end
        ST_RESET: begin
          if (r_timer == RST_LAST) begin
            w_state_nxt = ST_WAIT_LOCK;
            w_timer_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_WAIT_LOCK: begin
          if (r_lock_s) begin
            w_state_nxt  = ST_VERIFY;
            w_timer_nxt  = '0;
            w_noedge_nxt = '0;
          end else if (r_timer == LOCK_LAST) begin
            w_attempt_fail = 1'b1;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_VERIFY: begin
          if (w_lock_lost) begin
            w_attempt_fail = 1'b1;
          end else if (r_timer == STABLE_LAST) begin
            w_state_nxt = ST_LOCKED;
            w_timer_nxt = '0;
            w_retry_nxt = '0;
          end else begin
            w_timer_nxt = r_timer + 1'b1;
          end
        end
        ST_LOCKED: begin
          if (w_lock_lost) begin
            w_state_nxt = ST_RESET;
            w_timer_nxt = '0;
            w_loss_nxt  = (r_loss == 8'hFF) ? r_loss : r_loss + 8'd1;
          end
        end
        ST_FAIL: begin
          w_state_nxt = ST_FAIL;
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_timer_nxt = '0;
        end
      endcase

      if (w_attempt_fail) begin
        w_timer_nxt = '0;
        if (r_retry == RETRY_MAX) begin
          w_state_nxt = ST_FAIL;
        end else begin
          w_state_nxt = ST_RESET;
          w_retry_nxt = r_retry + 4'd1;
        end
      end
    end
  end

  // Outputs are decoded from the next state so they line up with r_state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_lock_m    <= 1'b0;
      r_lock_s    <= 1'b0;
      r_d1        <= 1'b0;
      r_d2        <= 1'b0;
      r_d3        <= 1'b0;
      r_state     <= ST_IDLE;
      r_timer     <= '0;
      r_noedge    <= '0;
      r_retry     <= '0;
      r_loss      <= '0;
      r_cdr_rst_n <= 1'b0;
      r_link_up   <= 1'b0;
      r_fail      <= 1'b0;
    end else begin
      r_lock_m    <= cdr_lock;
      r_lock_s    <= r_lock_m;
      r_d1        <= data_in;
      r_d2        <= r_d1;
      r_d3        <= r_d2;
      r_state     <= w_state_nxt;
      r_timer     <= w_timer_nxt;
      r_noedge    <= w_noedge_nxt;
      r_retry     <= w_retry_nxt;
      r_loss      <= w_loss_nxt;
      r_cdr_rst_n <= (w_state_nxt == ST_WAIT_LOCK) || (w_state_nxt == ST_VERIFY) ||
                     (w_state_nxt == ST_LOCKED);
      r_link_up   <= (w_state_nxt == ST_LOCKED);
      r_fail      <= (w_state_nxt == ST_FAIL);
    end
  end

  assign state     = r_state;
  assign cdr_rst_n = r_cdr_rst_n;
  assign link_up   = r_link_up;
  assign fail      = r_fail;
  assign retry_cnt = r_retry;
  assign loss_cnt  = r_loss;

endmodule

// File: tb/tb_cdr_lock_ctrl.sv
// Bench for cdr_lock_ctrl: vector table, hand-timed corner sequences, and a
// random phase checked every cycle against a history-based reference model.
module tb_cdr_lock_ctrl;

  localparam int RST_CYCLES    = 8;
  localparam int LOCK_TIMEOUT  = 100;
  localparam int STABLE_CYCLES = 64;
  localparam int NO_EDGE_LIMIT = 32;
  localparam int MAX_RETRY     = 3;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_RESET  = 3'd1;
  localparam logic [2:0] S_WAIT   = 3'd2;
  localparam logic [2:0] S_VERIFY = 3'd3;
  localparam logic [2:0] S_LOCKED = 3'd4;
  localparam logic [2:0] S_FAIL   = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       enable = 1'b0;
  logic       data_in = 1'b0;
  logic       cdr_lock = 1'b0;
  logic       cdr_rst_n;
  logic       link_up;
  logic       fail;
  logic [2:0] state;
  logic [3:0] retry_cnt;
  logic [7:0] loss_cnt;

  int checks = 0;
  int errors = 0;
  bit chk_on = 1'b0;
  bit tog_en = 1'b0;
  int tog_phase = 0;

  cdr_lock_ctrl #(
    .RST_CYCLES   (RST_CYCLES),
    .LOCK_TIMEOUT (LOCK_TIMEOUT),
    .STABLE_CYCLES(STABLE_CYCLES),
    .NO_EDGE_LIMIT(NO_EDGE_LIMIT),
    .MAX_RETRY    (MAX_RETRY),
    .CNT_W        (16)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .enable   (enable),
    .data_in  (data_in),
    .cdr_lock (cdr_lock),
    .cdr_rst_n(cdr_rst_n),
    .link_up  (link_up),
    .fail     (fail),
    .state    (state),
    .retry_cnt(retry_cnt),
    .loss_cnt (loss_cnt)
  );

  always #5 clk = ~clk;

  // Reference model: lock_s and data edges come from sample histories,
  // phase_age is the number of cycles spent in the current phase.
  logic lock_q[$] = '{1'b0, 1'b0};
  logic data_q[$] = '{1'b0, 1'b0, 1'b0};
  int m_st = 0;
  int m_age = 0;
  int m_quiet = 0;
  int m_retry = 0;
  int m_loss = 0;

  always @(posedge clk) begin : model
    logic ls;
    logic edge_seen;
    logic act;
    logic give_up;
    int   nq;
    if (!rst_n) begin
      lock_q = '{1'b0, 1'b0};
      data_q = '{1'b0, 1'b0, 1'b0};
      m_st = 0; m_age = 0; m_quiet = 0; m_retry = 0; m_loss = 0;
    end else begin
      ls        = lock_q[0];
      edge_seen = (data_q[0] != data_q[1]);
      act       = (m_quiet == NO_EDGE_LIMIT - 1) && !edge_seen;
      nq        = edge_seen ? 0 : ((m_quiet >= 65535) ? 65535 : m_quiet + 1);
      give_up   = 1'b0;
      void'(lock_q.pop_front());
      lock_q.push_back(cdr_lock);
      void'(data_q.pop_front());
      data_q.push_back(data_in);
      if (!enable) begin
        m_st = 0; m_age = 0; m_retry = 0; nq = 0;
      end else begin
        case (m_st)
          0: begin m_st = 1; m_age = 0; m_retry = 0; nq = 0; end
          1: if (m_age == RST_CYCLES - 1) begin m_st = 2; m_age = 0; end else m_age++;
          2: if (ls) begin m_st = 3; m_age = 0; nq = 0; end
             else if (m_age == LOCK_TIMEOUT - 1) give_up = 1'b1;
             else m_age++;
          3: if (!ls || act) give_up = 1'b1;
             else if (m_age == STABLE_CYCLES - 1) begin m_st = 4; m_age = 0; m_retry = 0; end
             else m_age++;
          4: if (!ls || act) begin
               m_st = 1; m_age = 0;
               if (m_loss < 255) m_loss++;
             end
          default: ;
        endcase
        if (give_up) begin
          m_age = 0;
          if (m_retry == MAX_RETRY) m_st = 5;
          else begin m_retry++; m_st = 1; end
        end
      end
      m_quiet = nq;
    end
  end

  always @(negedge clk) begin
    if (chk_on) begin
      logic exp_rstn;
      exp_rstn = (m_st == 2) || (m_st == 3) || (m_st == 4);
      checks++;
      if (state !== 3'(m_st) || cdr_rst_n !== exp_rstn || link_up !== (m_st == 4) ||
          fail !== (m_st == 5) || retry_cnt !== 4'(m_retry) || loss_cnt !== 8'(m_loss)) begin
        errors++;
        $display("FAIL model t=%0t got st=%0d rstn=%0b link=%0b fail=%0b retry=%0d loss=%0d want st=%0d rstn=%0b retry=%0d loss=%0d",
                 $time, state, cdr_rst_n, link_up, fail, retry_cnt, loss_cnt,
                 m_st, exp_rstn, m_retry, m_loss);
      end
    end
  end

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (tog_en) begin
        tog_phase++;
        if (tog_phase >= 3) begin
          tog_phase = 0;
          data_in = ~data_in;
        end
      end
    end
  endtask

  task automatic chk(input string name, input logic [2:0] es, input logic er, input logic el,
                     input logic ef, input logic [3:0] ert, input logic [7:0] elo);
    checks++;
    if (state !== es || cdr_rst_n !== er || link_up !== el || fail !== ef ||
        retry_cnt !== ert || loss_cnt !== elo) begin
      errors++;
      $display("FAIL %s got st=%0d rstn=%0b link=%0b fail=%0b retry=%0d loss=%0d want st=%0d rstn=%0b link=%0b fail=%0b retry=%0d loss=%0d",
               name, state, cdr_rst_n, link_up, fail, retry_cnt, loss_cnt,
               es, er, el, ef, ert, elo);
    end
  endtask

  task automatic wait_state(input logic [2:0] target, input int budget, input string name);
    int n = 0;
    while (state !== target && n < budget) begin
      cyc(1);
      n++;
    end
    checks++;
    if (state !== target) begin
      errors++;
      $display("FAIL %s timeout got st=%0d want st=%0d", name, state, target);
    end
  endtask

  typedef struct {
    int         n;
    logic       en;
    logic       lock;
    logic [2:0] st;
    logic       rstn;
    logic       link;
    logic       fl;
    logic [3:0] retry;
    logic [7:0] loss;
  } vec_t;

  vec_t vt[9];

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at t=%0t", $time);
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1);
  end

  initial begin
    int lock_run;
    int quiet_run;
    int exp_loss;

    // Nominal lock: enable at t=0, lock raised 20 cycles after CDR release.
    vt[0] = '{1,  1'b1, 1'b0, S_RESET,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[1] = '{7,  1'b1, 1'b0, S_RESET,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[2] = '{1,  1'b1, 1'b0, S_WAIT,   1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[3] = '{20, 1'b1, 1'b0, S_WAIT,   1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[4] = '{2,  1'b1, 1'b1, S_WAIT,   1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[5] = '{1,  1'b1, 1'b1, S_VERIFY, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[6] = '{63, 1'b1, 1'b1, S_VERIFY, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0};
    vt[7] = '{1,  1'b1, 1'b1, S_LOCKED, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0};
    vt[8] = '{10, 1'b1, 1'b1, S_LOCKED, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0};

    rst_n = 1'b0;
    cyc(3);
    chk_on = 1'b1;
    chk("reset", S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n  = 1'b1;
    tog_en = 1'b1;
    cyc(4);
    chk("idle_hold", S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    foreach (vt[i]) begin
      enable   = vt[i].en;
      cdr_lock = vt[i].lock;
      cyc(vt[i].n);
      chk($sformatf("vec%0d", i), vt[i].st, vt[i].rstn, vt[i].link, vt[i].fl,
          vt[i].retry, vt[i].loss);
    end

    // Lock never asserts: three retrainings, then FAIL 432 cycles after RESET entry.
    enable = 1'b0; cdr_lock = 1'b0;
    cyc(1);
    chk("disable", S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(4);
    enable = 1'b1;
    cyc(1);   chk("nl_reset",  S_RESET, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(107); chk("nl_wait0",  S_WAIT,  1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1);   chk("nl_retry1", S_RESET, 1'b0, 1'b0, 1'b0, 4'd1, 8'd0);
    cyc(108); chk("nl_retry2", S_RESET, 1'b0, 1'b0, 1'b0, 4'd2, 8'd0);
    cyc(108); chk("nl_retry3", S_RESET, 1'b0, 1'b0, 1'b0, 4'd3, 8'd0);
    cyc(107); chk("nl_last",   S_WAIT,  1'b1, 1'b0, 1'b0, 4'd3, 8'd0);
    cyc(1);   chk("nl_fail",   S_FAIL,  1'b0, 1'b0, 1'b1, 4'd3, 8'd0);
    cyc(20);  chk("nl_hold",   S_FAIL,  1'b0, 1'b0, 1'b1, 4'd3, 8'd0);
    enable = 1'b0;
    cyc(1);   chk("nl_exit",   S_IDLE,  1'b0, 1'b0, 1'b0, 4'd0, 8'd0);

    // One-cycle lock glitch at VERIFY cycle 30, then a clean retrain.
    cdr_lock = 1'b1;
    cyc(3);
    enable = 1'b1;
    wait_state(S_VERIFY, 20, "glitch_verify");
    cyc(30);
    cdr_lock = 1'b0;
    cyc(1);
    cdr_lock = 1'b1;
    cyc(1); chk("glitch_pre",   S_VERIFY, 1'b1, 1'b0, 1'b0, 4'd0, 8'd0);
    cyc(1); chk("glitch_retry", S_RESET,  1'b0, 1'b0, 1'b0, 4'd1, 8'd0);
    wait_state(S_LOCKED, 200, "glitch_relock");
    chk("glitch_locked", S_LOCKED, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);

    // Activity loss: data frozen while lock stays high.
    tog_en = 1'b0;
    cyc(30);
    chk("quiet_30", S_LOCKED, 1'b1, 1'b1, 1'b0, 4'd0, 8'd0);
    wait_state(S_RESET, 10, "act_loss");
    chk("act_loss_cnt", S_RESET, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);
    tog_en = 1'b1;

    // enable drop coinciding with lock_s drop in LOCKED goes to IDLE.
    wait_state(S_LOCKED, 200, "prio_lock");
    cdr_lock = 1'b0;
    cyc(2);
    enable = 1'b0;
    cyc(1);
    chk("prio_enable", S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 8'd1);

    // lock_s drop on the last VERIFY cycle is a failure, not a lock.
    cdr_lock = 1'b1;
    cyc(3);
    enable = 1'b1;
    wait_state(S_VERIFY, 20, "last_verify");
    cyc(61);
    cdr_lock = 1'b0;
    cyc(2); chk("last_pre",    S_VERIFY, 1'b1, 1'b0, 1'b0, 4'd0, 8'd1);
    cyc(1); chk("last_stable", S_RESET,  1'b0, 1'b0, 1'b0, 4'd1, 8'd1);
    cdr_lock = 1'b1;

    // Loss counter saturation.
    for (int i = 0; i < 260; i++) begin
      wait_state(S_LOCKED, 150, "sat_lock");
      cdr_lock = 1'b0;
      cyc(1);
      cdr_lock = 1'b1;
      cyc(2);
      exp_loss = (i + 2 > 255) ? 255 : i + 2;
      chk("sat_loss", S_RESET, 1'b0, 1'b0, 1'b0, 4'd0, 8'(exp_loss));
    end

    // Synchronous reset in the middle of WAIT_LOCK.
    cdr_lock = 1'b0;
    wait_state(S_WAIT, 20, "rst_wait");
    cyc(5);
    chk("rst_pre", S_WAIT, 1'b1, 1'b0, 1'b0, 4'd0, 8'd255);
    rst_n = 1'b0;
    cyc(1);
    chk("rst_mid", S_IDLE, 1'b0, 1'b0, 1'b0, 4'd0, 8'd0);
    rst_n = 1'b1;

    // Random phase, checked every cycle by the model.
    tog_en    = 1'b0;
    lock_run  = 1;
    quiet_run = 0;
    for (int i = 0; i < 6000; i++) begin
      cyc(1);
      rst_n = ($urandom_range(0, 999) != 0);
      if (enable) enable = ($urandom_range(0, 399) != 0);
      else        enable = ($urandom_range(0, 9) == 0);
      lock_run--;
      if (lock_run <= 0) begin
        cdr_lock = ~cdr_lock;
        lock_run = cdr_lock ? $urandom_range(20, 300) : $urandom_range(1, 250);
      end
      if (quiet_run > 0) begin
        quiet_run--;
      end else if ($urandom_range(0, 199) == 0) begin
        quiet_run = $urandom_range(20, 50);
      end else if ($urandom_range(0, 1) == 1) begin
        data_in = ~data_in;
      end
    end

    cyc(2);
    chk_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
